gcd_lcm_coproc_ctrl: RTL and testbench
======================================

Name: gcd_lcm_coproc_ctrl

Overview:
Sequencing controller for the GCD/LCM coprocessor. It accepts one packed command word from the core, which the core datapath's ALU3 produces as {op, marker, y, x}. It then runs GCD by repeated subtraction on a shared subtract/compare datapath, and for LCM runs a divide-by-subtraction followed by a shift-add multiply. The result is returned on a valid/ready response channel. The block sits between the core's ALU result/writeback path and the coprocessor datapath.

Parameters:
WIDTH, 8, operand width; x = cmd[WIDTH-1:0], y = cmd[2*WIDTH-1:WIDTH]
MARKER_BIT, 16, command-valid marker bit position in cmd
OP_BIT, 17, op select bit in cmd (0 = GCD, 1 = LCM)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets)
cmd_valid  in  1  command present
cmd  in  32  packed command; bits above OP_BIT ignored
cmd_ready  out  1  controller can accept a command (high only in IDLE)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
result  out  32  GCD or LCM, zero-extended from 2*WIDTH bits
rsp_err  out  1  command lacked marker bit
busy  out  1  high in any state other than IDLE

Behaviour:
- States are IDLE, GCD, DIV, MUL, DONE. All state and outputs update on the rising clk edge.
- Reset (reset==0 at an edge, including mid-operation): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, result=0, busy=0, and all internal registers (a, b, q, r, acc, count) =0. Any in-flight command is dropped with no response.
- IDLE:
  - cmd_ready=1. A handshake occurs when cmd_valid&&cmd_ready.
  - On handshake, latch a=x, b=y, op, x_saved, y_saved.
  - If cmd[MARKER_BIT]==0: go to DONE with result=0, rsp_err=1.
  - Otherwise go to GCD.
- GCD (one step per cycle):
  - If a==0: g=b. If b==0: g=a. If a==b: g=a. When g is found, exit to DONE (op=0) or DIV (op=1).
  - Else if a>b: a<=a-b. Else b<=b-a.
- LCM zero rule: if op=1 and (x_saved==0 or y_saved==0), go directly from GCD exit to DONE with result=0. DIV/MUL are skipped.
- DIV:
  - Entered with r=x_saved, q=0.
  - Each cycle: if r>=g, then r<=r-g and q<=q+1. Otherwise go to MUL.
  - g is nonzero here because operands are nonzero.
- MUL:
  - Shift-add q*y_saved over exactly WIDTH cycles. Bit count runs 0..WIDTH-1, LSB of q first, with acc width 2*WIDTH.
  - After the WIDTH-th cycle: result=acc, go to DONE.
- DONE:
  - rsp_valid=1. result and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On handshake: go to IDLE, rsp_valid=0, rsp_err=0. result is retained until the next command completes.
- cmd_ready is 0 outside IDLE, so commands offered while busy are not accepted and are not queued.
- Minimum command spacing: accept edge, then at least one GCD cycle, then DONE, then IDLE. A new command is accepted no earlier than the edge after the response handshake.
- Arithmetic: all subtracts are unsigned WIDTH-bit with no underflow, which the comparisons guarantee. The MUL accumulator is 2*WIDTH bits and cannot overflow since q*y <= (2^WIDTH-1)^2.
- Latency, from the accept edge to the first cycle with rsp_valid=1:
  - GCD: (number of subtract steps + 1) cycles.
  - LCM adds (x/g + 1) DIV cycles plus WIDTH MUL cycles.
  - Worst-case GCD: x=255, y=1 gives 255 cycles.

Test Plan:
- GCD(12,8): cmd=0x0001_080C, rsp_ready=1 -> rsp_valid rises 3 cycles after accept; result=4, rsp_err=0.
- LCM(12,8): cmd=0x0003_080C -> result=24; DIV takes 4 cycles (q=3), MUL takes 8; total 3+4+8=15 cycles after accept.
- Zero operands:
  - GCD(0,9), cmd=0x0001_0900 -> result=9.
  - LCM(0,9), cmd=0x0003_0900 -> result=0.
  - GCD(0,0) -> result=0.
  - Each completes in 1 GCD cycle.
- LCM(255,254): cmd=0x0003_FEFF -> result=64770 (0x0000_FD02).
- Missing marker: cmd=0x0000_080C -> rsp_err=1, result=0, no GCD cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> result/rsp_valid stable. cmd_valid pulses during busy are ignored (cmd_ready=0).
- Mid-operation reset: reset=0 during LCM MUL -> next edge IDLE, rsp_valid=0, result=0. A following GCD(12,8) completes correctly.

Source files
------------

// File: rtl/gcd_lcm_coproc_ctrl.sv
//------------------------------------------------------------------------------
// gcd_lcm_coproc_ctrl
//   Sequencer for the GCD/LCM coprocessor: subtractive GCD, divide-by-subtract
//   and shift-add multiply for LCM, valid/ready response channel.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gcd_lcm_coproc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int MARKER_BIT = 16,
    parameter int OP_BIT     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd,
    output logic        cmd_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GCD  = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 op_q, op_d;
    logic                 err_q, err_d;

    logic                 w_gcd_done;
    logic [WIDTH-1:0]     w_g;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_unused_cmd;

    assign w_unused_cmd = ^cmd[31:OP_BIT+1];

    // a==0 yields b; b==0 or a==b both yield a.
    assign w_gcd_done = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    assign w_g        = (a_q == '0) ? b_q : a_q;

    assign w_addend   = q_q[count_q] ? ({{WIDTH{1'b0}}, y_q} << count_q) : '0;
    assign w_acc_next = acc_q + w_addend;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        q_d      = q_q;
        r_d      = r_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d  = cmd[WIDTH-1:0];
                    b_d  = cmd[2*WIDTH-1:WIDTH];
                    x_d  = cmd[WIDTH-1:0];
                    y_d  = cmd[2*WIDTH-1:WIDTH];
                    op_d = cmd[OP_BIT];
                    if (!cmd[MARKER_BIT]) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_GCD;
                    end
                end
            end

            S_GCD: begin
                if (w_gcd_done) begin
                    // b holds the GCD from here on; DIV uses it as the divisor.
                    b_d = w_g;
                    if (!op_q) begin
                        result_d = {{WIDTH{1'b0}}, w_g};
                        state_d  = S_DONE;
                    end else if ((x_q == '0) || (y_q == '0)) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        r_d     = x_q;
                        q_d     = '0;
                        state_d = S_DIV;
                    end
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end

            S_DIV: begin
                if (r_q >= b_q) begin
                    r_d = r_q - b_q;
                    q_d = q_q + 1'b1;
                end else begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_MUL;
                end
            end

            S_MUL: begin
                acc_d   = w_acc_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d = w_acc_next;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            q_q      <= q_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_err   = err_q;
    assign result    = {{(32 - 2*WIDTH){1'b0}}, result_q};

endmodule

`default_nettype wire

// File: tb/tb_gcd_lcm_coproc_ctrl.sv
//------------------------------------------------------------------------------
// tb_gcd_lcm_coproc_ctrl
//   Directed self-checking bench for the GCD/LCM coprocessor controller.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_lcm_coproc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] result;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    gcd_lcm_coproc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Offer cmd for one edge (accept edge), return at the following negedge.
    task automatic accept_cmd(input logic [31:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    // Count edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %0d exp 0", result); end
        n_cmp++; if (busy !== 1'b0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_busy_err got %b%b exp 00", busy, rsp_err); end
        reset = 1'b1;
    endtask

    task automatic test_gcd();
        int lat;
        accept_cmd(32'h0001_080C);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gcd_busy got %b exp 1", busy); end
        wait_rsp(lat);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL gcd_12_8_latency got %0d exp 3", lat); end
        n_cmp++; if (result !== 32'd4 || rsp_err !== 1'b0) begin n_err++; $display("FAIL gcd_12_8 got %0d err %b exp 4 err 0", result, rsp_err); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL gcd_handshake got v%b r%b exp v0 r1", rsp_valid, cmd_ready); end
        // Worst-case subtract chain and ignored upper command bits.
        accept_cmd(32'h0001_01FF);
        wait_rsp(lat);
        n_cmp++; if (lat != 255 || result !== 32'd1) begin n_err++; $display("FAIL gcd_255_1 got %0d lat %0d exp 1 lat 255", result, lat); end
        @(negedge clk);
        accept_cmd(32'hFFFD_080C);
        wait_rsp(lat);
        n_cmp++; if (lat != 3 || result !== 32'd4) begin n_err++; $display("FAIL gcd_upper_bits got %0d lat %0d exp 4 lat 3", result, lat); end
        @(negedge clk);
    endtask

    task automatic test_lcm();
        int lat;
        accept_cmd(32'h0003_080C);
        wait_rsp(lat);
        n_cmp++; if (lat != 15) begin n_err++; $display("FAIL lcm_12_8_latency got %0d exp 15", lat); end
        n_cmp++; if (result !== 32'd24 || rsp_err !== 1'b0) begin n_err++; $display("FAIL lcm_12_8 got %0d err %b exp 24 err 0", result, rsp_err); end
        @(negedge clk);
        accept_cmd(32'h0003_FEFF);
        wait_rsp(lat);
        n_cmp++; if (result !== 32'h0000_FD02) begin n_err++; $display("FAIL lcm_255_254 got %h exp 0000fd02", result); end
        n_cmp++; if (lat != 519) begin n_err++; $display("FAIL lcm_255_254_latency got %0d exp 519", lat); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        accept_cmd(32'h0001_0900);
        wait_rsp(lat);
        n_cmp++; if (lat != 1 || result !== 32'd9) begin n_err++; $display("FAIL gcd_0_9 got %0d lat %0d exp 9 lat 1", result, lat); end
        @(negedge clk);
        accept_cmd(32'h0003_0900);
        wait_rsp(lat);
        n_cmp++; if (lat != 1 || result !== 32'd0) begin n_err++; $display("FAIL lcm_0_9 got %0d lat %0d exp 0 lat 1", result, lat); end
        @(negedge clk);
        accept_cmd(32'h0001_0005);
        wait_rsp(lat);
        n_cmp++; if (lat != 1 || result !== 32'd5) begin n_err++; $display("FAIL gcd_5_0 got %0d lat %0d exp 5 lat 1", result, lat); end
        @(negedge clk);
        accept_cmd(32'h0001_0000);
        wait_rsp(lat);
        n_cmp++; if (lat != 1 || result !== 32'd0) begin n_err++; $display("FAIL gcd_0_0 got %0d lat %0d exp 0 lat 1", result, lat); end
        @(negedge clk);
    endtask

    task automatic test_no_marker();
        int lat;
        accept_cmd(32'h0001_0F0F);
        wait_rsp(lat);
        @(negedge clk);
        accept_cmd(32'h0000_080C);
        wait_rsp(lat);
        n_cmp++; if (lat != 0) begin n_err++; $display("FAIL nomarker_latency got %0d exp 0", lat); end
        n_cmp++; if (rsp_err !== 1'b1 || result !== 32'd0) begin n_err++; $display("FAIL nomarker got %0d err %b exp 0 err 1", result, rsp_err); end
        @(negedge clk);
        n_cmp++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL nomarker_clear got err %b v %b exp 0 0", rsp_err, rsp_valid); end
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        accept_cmd(32'h0001_080C);
        // Offer a competing command while busy; it must be dropped.
        cmd_valid = 1'b1;
        cmd       = 32'h0001_0303;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_cmd_ready_busy got %b exp 0", cmd_ready); end
        wait_rsp(lat);
        cmd_valid = 1'b0;
        cmd       = '0;
        n_cmp++; if (lat != 3 || result !== 32'd4) begin n_err++; $display("FAIL bp_first got %0d lat %0d exp 4 lat 3", result, lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1 || result !== 32'd4) begin n_err++; $display("FAIL bp_hold_%0d got v%b %0d exp v1 4", i, rsp_valid, result); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || result !== 32'd4) begin n_err++; $display("FAIL bp_release got v%b %0d exp v0 4", rsp_valid, result); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_queue got busy %b exp 0", busy); end
    endtask

    task automatic test_mid_reset();
        int lat;
        accept_cmd(32'h0003_080C);
        // 3 GCD + 4 DIV edges already elapsed after 7 more; land inside MUL.
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_state got v%b b%b r%b exp 0 0 1", rsp_valid, busy, cmd_ready); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL midrst_result got %0d exp 0", result); end
        accept_cmd(32'h0001_080C);
        wait_rsp(lat);
        n_cmp++; if (lat != 3 || result !== 32'd4) begin n_err++; $display("FAIL midrst_after got %0d lat %0d exp 4 lat 3", result, lat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_gcd();
        test_lcm();
        test_zero();
        test_no_marker();
        test_backpressure();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
